// File: rtl/operand_return_router_if.sv
// Bank-side request/data and queue-side operand/credit bundle of the operand return router.
// Signal names are relative to the router: _i signals are driven into it, _o signals come out of it.
interface operand_return_router_if #(
    parameter int NrBanks         = 8,
    parameter int NrOperandQueues = 9,
    parameter int ElenW           = 64,
    parameter int QIdxW           = (NrOperandQueues > 1) ? $clog2(NrOperandQueues) : 1
);
    logic [NrBanks-1:0]                    req_valid_i;
    logic [NrBanks-1:0][QIdxW-1:0]         req_queue_i;
    logic [NrBanks-1:0][ElenW-1:0]         vrf_operand_i;
    logic [NrOperandQueues-1:0][ElenW-1:0] operand_o;
    logic [NrOperandQueues-1:0]            operand_valid_o;
    logic [NrOperandQueues-1:0]            operand_issued_o;
    logic [NrOperandQueues-1:0]            operand_consumed_i;
    logic [NrOperandQueues-1:0]            credit_avail_o;

    modport master (
        output req_valid_i, req_queue_i, vrf_operand_i, operand_consumed_i,
        input  operand_o, operand_valid_o, operand_issued_o, credit_avail_o
    );

    modport slave (
        input  req_valid_i, req_queue_i, vrf_operand_i, operand_consumed_i,
        output operand_o, operand_valid_o, operand_issued_o, credit_avail_o
    );
endinterface

// File: rtl/operand_return_router.sv
// Tags granted VRF bank reads with their destination queue, routes the returning data
// to that queue as a registered operand/valid pair, and keeps per-queue read credits.
module operand_return_router #(
    parameter int NrBanks         = 8,
    parameter int NrOperandQueues = 9,
    parameter int ReadLatency     = 1,
    parameter int MaxInflight     = 2,
    parameter int ElenW           = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    operand_return_router_if.slave bus,
    output logic                   error_o
);
    localparam int QIdxW = (NrOperandQueues > 1) ? $clog2(NrOperandQueues) : 1;
    localparam int CntW  = $clog2(MaxInflight + 1);

    logic [NrBanks-1:0][ReadLatency-1:0]            tag_vld_q;
    logic [NrBanks-1:0][ReadLatency-1:0][QIdxW-1:0] tag_qidx_q;

    logic [NrOperandQueues-1:0][ElenW-1:0] operand_q, operand_d;
    logic [NrOperandQueues-1:0]            operand_valid_q, operand_valid_d;
    logic [NrOperandQueues-1:0][CntW-1:0]  credit_q, credit_d;
    logic [NrOperandQueues-1:0]            issued;
    logic                                  error_q, error_d;
    logic                                  collision, multi_grant, credit_err;

    // Tag shift register: stage 0 loads every cycle, the last stage lines up with bank data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_vld_q  <= '0;
            tag_qidx_q <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                tag_vld_q[b][0]  <= bus.req_valid_i[b];
                tag_qidx_q[b][0] <= bus.req_queue_i[b];
                for (int s = 1; s < ReadLatency; s++) begin
                    tag_vld_q[b][s]  <= tag_vld_q[b][s-1];
                    tag_qidx_q[b][s] <= tag_qidx_q[b][s-1];
                end
            end
        end
    end

    // Route: lowest bank index wins a queue, any later claimant is a collision.
    always_comb begin
        operand_d       = operand_q;
        operand_valid_d = '0;
        collision       = 1'b0;
        for (int q = 0; q < NrOperandQueues; q++) begin
            for (int b = 0; b < NrBanks; b++) begin
                if (tag_vld_q[b][ReadLatency-1] &&
                    tag_qidx_q[b][ReadLatency-1] == QIdxW'(q)) begin
                    if (operand_valid_d[q]) begin
                        collision = 1'b1;
                    end else begin
                        operand_valid_d[q] = 1'b1;
                        operand_d[q]       = bus.vrf_operand_i[b];
                    end
                end
            end
        end
    end

    always_comb begin
        issued      = '0;
        multi_grant = 1'b0;
        for (int q = 0; q < NrOperandQueues; q++) begin
            for (int b = 0; b < NrBanks; b++) begin
                if (bus.req_valid_i[b] && bus.req_queue_i[b] == QIdxW'(q)) begin
                    if (issued[q]) multi_grant = 1'b1;
                    issued[q] = 1'b1;
                end
            end
        end
    end

    // Credits saturate at both ends; hitting either end is a protocol violation.
    always_comb begin
        credit_d   = credit_q;
        credit_err = 1'b0;
        for (int q = 0; q < NrOperandQueues; q++) begin
            case ({issued[q], bus.operand_consumed_i[q]})
                2'b10: begin
                    if (credit_q[q] == '0) credit_err = 1'b1;
                    else                   credit_d[q] = credit_q[q] - CntW'(1);
                end
                2'b01: begin
                    if (credit_q[q] == CntW'(MaxInflight)) credit_err = 1'b1;
                    else                                   credit_d[q] = credit_q[q] + CntW'(1);
                end
                default: ;
            endcase
        end
    end

    assign error_d = error_q | collision | multi_grant | credit_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            operand_q       <= '0;
            operand_valid_q <= '0;
            credit_q        <= {NrOperandQueues{CntW'(MaxInflight)}};
            error_q         <= 1'b0;
        end else begin
            operand_q       <= operand_d;
            operand_valid_q <= operand_valid_d;
            credit_q        <= credit_d;
            error_q         <= error_d;
        end
    end

    always_comb begin
        bus.credit_avail_o = '0;
        for (int q = 0; q < NrOperandQueues; q++) begin
            bus.credit_avail_o[q] = (credit_q[q] != '0);
        end
    end

    assign bus.operand_o        = operand_q;
    assign bus.operand_valid_o  = operand_valid_q;
    assign bus.operand_issued_o = issued;
    assign error_o              = error_q;
endmodule

// File: tb/tb_operand_return_router.sv
// Scoreboard bench: two routers (read latency 1 and 3) sharing one clock.
module tb_operand_return_router;
    localparam int NB = 8;
    localparam int NQ = 8;
    localparam int EW = 64;
    localparam int QW = 3;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst3, err1, err3;
    always #5 clk = ~clk;

    operand_return_router_if #(.NrBanks(NB), .NrOperandQueues(NQ), .ElenW(EW)) if1 ();
    operand_return_router_if #(.NrBanks(NB), .NrOperandQueues(NQ), .ElenW(EW)) if3 ();

    operand_return_router #(.NrBanks(NB), .NrOperandQueues(NQ), .ReadLatency(1),
                            .MaxInflight(2), .ElenW(EW))
        dut1 (.clk_i(clk), .rst_i(rst1), .bus(if1), .error_o(err1));
    operand_return_router #(.NrBanks(NB), .NrOperandQueues(NQ), .ReadLatency(3),
                            .MaxInflight(2), .ElenW(EW))
        dut3 (.clk_i(clk), .rst_i(rst3), .bus(if3), .error_o(err3));

    exp_t sb1[NQ][$];
    exp_t sb3[NQ][$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    int   t;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] bdata(int b, int c);
        logic [31:0] bb, cc;
        bb = b;
        cc = c;
        return {bb[7:0], 24'hC3A55A, cc};
    endfunction

    // Advance one cycle and return the inputs to idle, bank data following a known pattern.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int b = 0; b < NB; b++) begin
            if1.vrf_operand_i[b] = bdata(b, cyc);
            if3.vrf_operand_i[b] = bdata(b, cyc);
        end
        if1.req_valid_i = '0;  if1.req_queue_i = '0;  if1.operand_consumed_i = '0;
        if3.req_valid_i = '0;  if3.req_queue_i = '0;  if3.operand_consumed_i = '0;
    endtask

    task automatic grant1(int b, int q);
        if1.req_valid_i[b] = 1'b1;
        if1.req_queue_i[b] = QW'(q);
        sb1[q].push_back('{bdata(b, cyc + 1), cyc + 2});
    endtask

    task automatic grant3(int b, int q);
        if3.req_valid_i[b] = 1'b1;
        if3.req_queue_i[b] = QW'(q);
        sb3[q].push_back('{bdata(b, cyc + 3), cyc + 4});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int q = 0; q < NQ; q++) begin
                if (if1.operand_valid_o[q] === 1'b1) begin
                    if (sb1[q].size() == 0) chk("dut1 unexpected valid", 64'(if1.operand_valid_o[q]), 0);
                    else begin
                        e = sb1[q].pop_front();
                        chk("dut1 data", if1.operand_o[q], e.data);
                        chk("dut1 arrival cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (sb1[q].size() > 0 && sb1[q][0].cyc < cyc) begin
                    chk("dut1 missing valid", 64'(sb1[q][0].cyc), 64'(cyc));
                    void'(sb1[q].pop_front());
                end
                if (if3.operand_valid_o[q] === 1'b1) begin
                    if (sb3[q].size() == 0) chk("dut3 unexpected valid", 64'(if3.operand_valid_o[q]), 0);
                    else begin
                        e = sb3[q].pop_front();
                        chk("dut3 data", if3.operand_o[q], e.data);
                        chk("dut3 arrival cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (sb3[q].size() > 0 && sb3[q][0].cyc < cyc) begin
                    chk("dut3 missing valid", 64'(sb3[q][0].cyc), 64'(cyc));
                    void'(sb3[q].pop_front());
                end
            end
        end
    end

    initial begin
        rst1 = 1'b1;
        rst3 = 1'b1;
        if1.req_valid_i = '0;  if1.req_queue_i = '0;  if1.operand_consumed_i = '0;  if1.vrf_operand_i = '0;
        if3.req_valid_i = '0;  if3.req_queue_i = '0;  if3.operand_consumed_i = '0;  if3.vrf_operand_i = '0;
        repeat (3) step();
        rst1 = 1'b0;
        rst3 = 1'b0;
        chk("rst valid1", 64'(if1.operand_valid_o), 0);
        chk("rst operand1 zero", 64'(if1.operand_o == '0), 1);
        chk("rst credit1", 64'(if1.credit_avail_o), 64'hFF);
        chk("rst credit3", 64'(if3.credit_avail_o), 64'hFF);
        chk("rst err1", 64'(err1), 0);
        chk("rst err3", 64'(err3), 0);
        mon_en = 1'b1;

        // Single read: bank 3 -> queue 2
        step();
        t = cyc;
        if1.req_valid_i[3] = 1'b1;
        if1.req_queue_i[3] = QW'(2);
        sb1[2].push_back('{64'hDEADBEEF_0BADF00D, t + 2});
        #1 chk("issued pulse q2", 64'(if1.operand_issued_o), 64'h04);
        step();
        if1.vrf_operand_i[3] = 64'hDEADBEEF_0BADF00D;
        chk("credit q2 after grant", 64'(if1.credit_avail_o[2]), 1);
        step();
        chk("credit q2 still", 64'(if1.credit_avail_o[2]), 1);
        step();
        chk("valid q2 one cycle", 64'(if1.operand_valid_o[2]), 0);
        chk("operand q2 held", if1.operand_o[2], 64'hDEADBEEF_0BADF00D);
        if1.operand_consumed_i[2] = 1'b1;
        step();

        // Credit exhaustion on queue 5
        grant1(0, 5);
        step();
        grant1(1, 5);
        step();
        chk("credit q5 exhausted", 64'(if1.credit_avail_o[5]), 0);
        step();
        chk("credit q5 still exhausted", 64'(if1.credit_avail_o[5]), 0);
        if1.operand_consumed_i[5] = 1'b1;
        step();
        chk("credit q5 returned", 64'(if1.credit_avail_o[5]), 1);
        if1.operand_consumed_i[5] = 1'b1;
        step();
        chk("no error after exhaustion", 64'(err1), 0);

        // Issue and consume together on queue 0 with one credit left
        grant1(2, 0);
        step();
        grant1(2, 0);
        if1.operand_consumed_i[0] = 1'b1;
        step();
        chk("credit q0 after issue+consume", 64'(if1.credit_avail_o[0]), 1);
        chk("no error issue+consume", 64'(err1), 0);
        grant1(4, 0);
        step();
        chk("credit q0 counter was 1", 64'(if1.credit_avail_o[0]), 0);
        if1.operand_consumed_i[0] = 1'b1;
        step();
        if1.operand_consumed_i[0] = 1'b1;
        step();
        chk("credits restored", 64'(if1.credit_avail_o), 64'hFF);
        chk("no error before collision", 64'(err1), 0);

        // Collision: banks 1 and 6 both to queue 4, bank 1 wins
        if1.req_valid_i[1] = 1'b1;  if1.req_queue_i[1] = QW'(4);
        if1.req_valid_i[6] = 1'b1;  if1.req_queue_i[6] = QW'(4);
        sb1[4].push_back('{bdata(1, cyc + 1), cyc + 2});
        step();
        chk("collision single decrement", 64'(if1.credit_avail_o[4]), 1);
        step();
        chk("collision error", 64'(err1), 1);
        grant1(2, 4);
        step();
        chk("credit q4 after collision+grant", 64'(if1.credit_avail_o[4]), 0);
        repeat (3) step();
        chk("error sticky", 64'(err1), 1);
        if1.operand_consumed_i[4] = 1'b1;
        step();
        if1.operand_consumed_i[4] = 1'b1;
        repeat (3) step();

        // Reset mid-flight
        t = cyc;
        if1.req_valid_i[5] = 1'b1;
        if1.req_queue_i[5] = QW'(7);
        step();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset flight valid", 64'(if1.operand_valid_o), 0);
            chk("reset flight credit", 64'(if1.credit_avail_o), 64'hFF);
            chk("reset flight error", 64'(err1), 0);
            step();
        end

        // Latency sweep on the ReadLatency=3 router
        for (int k = 0; k < 10; k++) begin
            for (int b = 0; b < NB; b++) grant3(b, b);
            if3.operand_consumed_i = '1;
            step();
        end
        repeat (6) step();
        chk("sweep credits", 64'(if3.credit_avail_o), 64'hFF);
        chk("sweep error", 64'(err3), 0);

        for (int q = 0; q < NQ; q++) begin
            chk("sb1 drained", 64'(sb1[q].size()), 0);
            chk("sb3 drained", 64'(sb3[q].size()), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
